// File: rtl/sram_wr_arbiter_pkg.sv
// Shared definitions for the SRAM write-port arbiter.
//   SramAw / SramDw : default SRAM address / data widths
//   GrantIdxW       : width of a requester index (supports up to 8 requesters)
//   req_idx_t       : requester index type
//   wrap_inc()      : (idx + 1) mod n for the round-robin pointer
package sram_wr_arbiter_pkg;

    localparam int unsigned SramAw    = 16;
    localparam int unsigned SramDw    = 128;
    localparam int unsigned GrantIdxW = 3;

    typedef logic [GrantIdxW-1:0] req_idx_t;
    typedef logic [GrantIdxW:0]   idx_ext_t;

    function automatic req_idx_t wrap_inc(input req_idx_t idx, input int unsigned n);
        idx_ext_t nxt;
        nxt = {1'b0, idx} + idx_ext_t'(1);
        if (nxt >= idx_ext_t'(n)) begin
            nxt = '0;
        end
        return nxt[GrantIdxW-1:0];
    endfunction

endpackage

// File: rtl/sram_wr_arbiter_if.sv
// Request and SRAM write-port bundle of the arbiter.
//   req_valid/req_ready : per-requester handshake
//   req_addr/req_data   : flattened, requester i at [i*AW +: AW] / [i*DW +: DW]
//   WE/WriteAddress/WriteBus : registered SRAM write port
// slave  : the arbiter side; master : the requester/SRAM side.
interface sram_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 128
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               WE;
    logic [AW-1:0]      WriteAddress;
    logic [DW-1:0]      WriteBus;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, WE, WriteAddress, WriteBus
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, WE, WriteAddress, WriteBus
    );

endinterface

// File: rtl/sram_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_mask_i  : candidate requesters
//   ptr_i       : highest-priority index this cycle
//   grant_o     : one-hot grant (zero when nothing requested)
//   grant_idx_o : index of the granted requester
//   any_grant_o : a grant was made
// Search order is ptr, ptr+1, ... wrapping modulo NREQ.
module rr_pick
    import sram_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req_mask_i,
    input  req_idx_t        ptr_i,
    output logic [NREQ-1:0] grant_o,
    output req_idx_t        grant_idx_o,
    output logic            any_grant_o
);

    int unsigned ptr_ext;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        ptr_ext     = int'(ptr_i);
        // k is the distance from ptr; at most one i matches a given k.
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any_grant_o && req_mask_i[i] &&
                    ((ptr_ext + k == i) || (ptr_ext + k == i + NREQ))) begin
                    any_grant_o = 1'b1;
                    grant_o[i]  = 1'b1;
                    grant_idx_o = req_idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sram_wr_arbiter.sv
// sram_wr_arbiter: shares one SRAM write port between NREQ requesters.
// Each requester owns a one-entry slot; a round-robin pick drains one full slot per clock
// onto the registered WE/WriteAddress/WriteBus.
//   clock, reset_n : clock and asynchronous active-low reset
//   enable         : 1 = grants allowed; 0 = slots still accept, nothing issues
//   bus (slave)    : request handshake and SRAM write port
//   grant_id       : requester whose write is on the bus while WE=1
//   idle           : all slots empty and WE=0
//   write_count    : writes issued since reset (wraps)
module sram_wr_arbiter
    import sram_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = SramAw,
    parameter int unsigned DW   = SramDw
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    sram_wr_arbiter_if.slave     bus,
    output req_idx_t             grant_id,
    output logic                 idle,
    output logic [31:0]          write_count
);

    // Slot storage
    logic [NREQ-1:0] slot_full_q, slot_full_d;
    logic [AW-1:0]   slot_addr_q [NREQ];
    logic [AW-1:0]   slot_addr_d [NREQ];
    logic [DW-1:0]   slot_data_q [NREQ];
    logic [DW-1:0]   slot_data_d [NREQ];

    // Scheduler and output registers
    req_idx_t        ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    req_idx_t        grant_id_q, grant_id_d;
    logic [31:0]     write_count_q, write_count_d;

    // Arbitration
    logic [NREQ-1:0] req_mask;
    logic [NREQ-1:0] grant;
    req_idx_t        grant_idx;
    logic            any_grant;
    logic [NREQ-1:0] accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // With enable low no slot is a candidate, so full slots also report not-ready.
    assign req_mask = enable ? slot_full_q : '0;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_mask_i  (req_mask),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // Ready never looks at req_valid, so a granted slot can be refilled on the same edge.
    assign bus.req_ready = ~slot_full_q | grant;
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin : slot_next
        slot_full_d = slot_full_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                slot_full_d[i] = 1'b1;
                slot_addr_d[i] = bus.req_addr[i*AW +: AW];
                slot_data_d[i] = bus.req_data[i*DW +: DW];
            end else if (grant[i]) begin
                slot_full_d[i] = 1'b0;
            end
        end
    end

    // One-hot AND-OR mux of the granted slot.
    always_comb begin : grant_mux
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | slot_addr_q[i];
                sel_data = sel_data | slot_data_q[i];
            end
        end
    end

    always_comb begin : issue_next
        we_d          = any_grant;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        write_count_d = write_count_q;
        if (any_grant) begin
            waddr_d       = sel_addr;
            wdata_d       = sel_data;
            grant_id_d    = grant_idx;
            ptr_d         = wrap_inc(grant_idx, NREQ);
            write_count_d = write_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_full_q   <= '0;
            slot_addr_q   <= '{default: '0};
            slot_data_q   <= '{default: '0};
            ptr_q         <= '0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            grant_id_q    <= '0;
            write_count_q <= '0;
        end else begin
            slot_full_q   <= slot_full_d;
            slot_addr_q   <= slot_addr_d;
            slot_data_q   <= slot_data_d;
            ptr_q         <= ptr_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            grant_id_q    <= grant_id_d;
            write_count_q <= write_count_d;
        end
    end

    assign bus.WE           = we_q;
    assign bus.WriteAddress = waddr_q;
    assign bus.WriteBus     = wdata_q;
    assign grant_id         = grant_id_q;
    assign write_count      = write_count_q;
    assign idle             = ~|slot_full_q & ~we_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Self-checking bench for sram_wr_arbiter (NREQ=4, AW=16, DW=128).
// A negedge monitor keeps per-requester expected-write queues: accepted requests are pushed,
// each WE cycle pops the granted requester's queue and compares address and data.
module tb_sram_wr_arbiter;
    import sram_wr_arbiter_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 128;
    localparam int unsigned ENTRY_W = AW + DW;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            en;
        logic [NREQ-1:0] ready;
        logic            we;
        req_idx_t        gid;
        logic            idl;
        logic [31:0]     wc;
        logic [AW-1:0]   waddr;
    } vec_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    req_idx_t    grant_id;
    logic        idle;
    logic [31:0] write_count;

    sram_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    sram_wr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .bus         (bus),
        .grant_id    (grant_id),
        .idle        (idle),
        .write_count (write_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Scoreboard state
    entry_t          exp_q [NREQ][$];
    logic [NREQ-1:0] pushed_last = '0;
    int unsigned     wait_cnt [NREQ];
    int unsigned     writes_seen = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] mk_data(input int unsigned a);
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_sb();
        for (int i = 0; i < NREQ; i++) begin
            exp_q[i].delete();
            wait_cnt[i] = 0;
        end
        pushed_last = '0;
        writes_seen = 0;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        enable        = 1'b0;
        bus.req_valid = '0;
        clear_sb();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        int     g;
        entry_t e;
        logic [NREQ-1:0] acc;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.WE) begin
                    writes_seen++;
                    g = int'(grant_id);
                    if (g >= NREQ || exp_q[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_write: grant_id %0d addr %0h with no pending entry",
                                 g, bus.WriteAddress);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("sb_addr", bus.WriteAddress, e[ENTRY_W-1 -: AW]);
                        check("sb_data", bus.WriteBus, e[DW-1:0]);
                        wait_cnt[g] = 0;
                    end
                    // A slot that was full at this grant edge has waited one more grant.
                    for (int i = 0; i < NREQ; i++) begin
                        if (i != g) begin
                            if (exp_q[i].size() > (pushed_last[i] ? 1 : 0)) begin
                                wait_cnt[i]++;
                                check("sb_wait_bound", wait_cnt[i] <= NREQ - 1, 1'b1);
                            end else begin
                                wait_cnt[i] = 0;
                            end
                        end
                    end
                end
                acc = bus.req_valid & bus.req_ready;
                for (int i = 0; i < NREQ; i++) begin
                    if (acc[i]) begin
                        exp_q[i].push_back({bus.req_addr[i*AW +: AW], bus.req_data[i*DW +: DW]});
                    end
                end
                pushed_last = acc;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [13];

    initial begin : main
        int              k, nwe, first, last, exp_gid, acc_total, qs;
        logic            started;
        int unsigned     sent [NREQ];
        logic [AW-1:0]   nxt_addr [NREQ];
        logic [DW-1:0]   nxt_data [NREQ];
        logic [NREQ-1:0] need_upd;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] one;

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        one           = 1;

        // T1 + T4 as a cycle table: r0 single write, then slots 1 and 3 held with enable=0.
        //            valid    en    ready    we    gid   idle  wc     waddr
        vecs[0]  = '{4'b0001, 1'b1, 4'b1111, 1'b0, 3'd0, 1'b1, 32'd0, 16'h0000};
        vecs[1]  = '{4'b0000, 1'b1, 4'b1111, 1'b0, 3'd0, 1'b0, 32'd0, 16'h0000};
        vecs[2]  = '{4'b0000, 1'b1, 4'b1111, 1'b1, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[3]  = '{4'b1010, 1'b0, 4'b1111, 1'b0, 3'd0, 1'b1, 32'd1, 16'h0010};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0101, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0101, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0101, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0101, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0101, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0111, 1'b0, 3'd0, 1'b0, 32'd1, 16'h0010};
        vecs[10] = '{4'b0000, 1'b1, 4'b1111, 1'b1, 3'd1, 1'b0, 32'd2, 16'h0021};
        vecs[11] = '{4'b0000, 1'b1, 4'b1111, 1'b1, 3'd3, 1'b0, 32'd3, 16'h0023};
        vecs[12] = '{4'b0000, 1'b1, 4'b1111, 1'b0, 3'd3, 1'b1, 32'd3, 16'h0023};

        do_reset();
        set_req(0, 16'h0010, {16{8'hA5}});
        set_req(1, 16'h0021, mk_data(32'h21));
        set_req(2, 16'h0022, mk_data(32'h22));
        set_req(3, 16'h0023, mk_data(32'h23));
        for (int s = 0; s < 13; s++) begin
            @(posedge clock);
            #1;
            bus.req_valid = vecs[s].valid;
            enable        = vecs[s].en;
            @(negedge clock);
            check($sformatf("tbl%0d_ready", s), bus.req_ready, vecs[s].ready);
            check($sformatf("tbl%0d_we", s), bus.WE, vecs[s].we);
            check($sformatf("tbl%0d_gid", s), grant_id, vecs[s].gid);
            check($sformatf("tbl%0d_idle", s), idle, vecs[s].idl);
            check($sformatf("tbl%0d_wc", s), write_count, vecs[s].wc);
            check($sformatf("tbl%0d_waddr", s), bus.WriteAddress, vecs[s].waddr);
        end

        // T3: requester 2 alone, 16 consecutive writes with no bubble.
        k = 0; nwe = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (k < 16) begin
                set_req(2, AW'(16'h0100 + k), mk_data(32'h100 + k));
                bus.req_valid = 4'b0100;
            end else begin
                bus.req_valid = '0;
            end
            @(negedge clock);
            if (bus.req_valid[2]) begin
                check("t3_ready", bus.req_ready[2], 1'b1);
                if (bus.req_ready[2]) k++;
            end
            if (bus.WE) begin
                nwe++;
                if (first < 0) first = c;
                last = c;
                check("t3_gid", grant_id, 3'd2);
            end
        end
        check("t3_we_cycles", nwe, 16);
        check("t3_no_bubble", last - first, 15);

        // T2: all four valid every cycle, 100 writes each.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(i), mk_data(i));
            sent[i] = 0;
        end
        exp_gid = 0; nwe = 0; started = 1'b0;
        for (int c = 0; c < 500 && nwe < 400; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) bus.req_valid[i] = (sent[i] < 100);
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) sent[i]++;
            end
            if (started) check("t2_we_held", bus.WE, 1'b1);
            if (bus.WE) begin
                started = 1'b1;
                check("t2_gid", grant_id, exp_gid);
                if (nwe < 300) begin
                    // Only the slot being granted this cycle is ready; the rest are waiting.
                    exp_rdy = one << ((exp_gid + 1) % NREQ);
                    check("t2_ready", bus.req_ready, exp_rdy);
                end
                exp_gid = (exp_gid + 1) % NREQ;
                nwe++;
            end
        end
        check("t2_writes", nwe, 400);
        check("t2_write_count", write_count, 32'd400);
        @(posedge clock);
        #1 bus.req_valid = '0;
        repeat (2) @(negedge clock);
        check("t2_idle", idle, 1'b1);

        // T5: reset in mid-cycle with three slots full and WE=1.
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) set_req(i, AW'(16'h0500 + i), mk_data(32'h500 + i));
        bus.req_valid = 4'b0111;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1 bus.req_valid = '0;
        #2;
        check("t5_pre_we", bus.WE, 1'b1);
        check("t5_pre_ready", bus.req_ready == 4'b1111, 1'b0);
        reset_n = 1'b0;
        clear_sb();
        #1;
        check("t5_rst_we", bus.WE, 1'b0);
        check("t5_rst_addr", bus.WriteAddress, '0);
        check("t5_rst_data", bus.WriteBus, '0);
        check("t5_rst_gid", grant_id, '0);
        check("t5_rst_wc", write_count, '0);
        check("t5_rst_idle", idle, 1'b1);
        check("t5_rst_ready", bus.req_ready, 4'b1111);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("t5_no_stale", bus.WE, 1'b0);
        end
        check("t5_wc_after", write_count, '0);

        // T6: random valid patterns, per-requester FIFO order and completeness.
        enable = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            nxt_addr[i] = AW'(i << 12);
            nxt_data[i] = rand128();
            set_req(i, nxt_addr[i], nxt_data[i]);
        end
        need_upd = '0;
        acc_total = 0;
        for (int c = 0; c < 40000 && acc_total < 10000; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (need_upd[i]) begin
                    nxt_addr[i] = nxt_addr[i] + 1'b1;
                    nxt_data[i] = rand128();
                    set_req(i, nxt_addr[i], nxt_data[i]);
                end
                bus.req_valid[i] = ($urandom_range(0, 99) < 60);
            end
            need_upd = '0;
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    need_upd[i] = 1'b1;
                    acc_total++;
                end
            end
        end
        check("t6_accepts", acc_total >= 10000, 1'b1);
        @(posedge clock);
        #1 bus.req_valid = '0;
        for (int c = 0; c < 20 && !idle; c++) @(negedge clock);
        @(negedge clock);
        check("t6_drain_idle", idle, 1'b1);
        qs = 0;
        for (int i = 0; i < NREQ; i++) qs += exp_q[i].size();
        check("t6_lost", qs, 0);
        check("t6_write_count", write_count, writes_seen);
        check("t6_all_written", writes_seen, acc_total);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
